fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the instruction decoder. Holds the PC and
//  issues word fetches to instruction memory over a valid/ready request channel. Buffers
//  in-order responses in a small FIFO and presents {instr, instr_pc} to decode with a
//  valid/ready handshake. Handles redirects (branch/jump) by flushing buffered and in-flight fetches.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded at reset; low 2 bits must be 0
//  FIFO_DEPTH  2              instruction buffer entries; also max outstanding+buffered (power of 2, >=2)
// PORTS
//  clk             in   1   rising-edge clock
//  rst_n           in   1   synchronous active-low reset
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  32  word-aligned fetch address
//  imem_rsp_valid  in   1   response valid; in request order, never back-pressured
//  imem_rsp_data   in   32  fetched instruction word
//  redirect_valid  in   1   redirect fetch (taken branch/jump)
//  redirect_pc     in   32  redirect target; bits [1:0] ignored (treated as 0)
//  instr_valid     out  1   decode-side entry valid
//  instr_ready     in   1   decode accepts entry
//  instr           out  32  instruction to decoder
//  instr_pc        out  32  PC of instr
//  illegal_in      in   1   decoder illegal flag for current instr (FETCH_ILLEGAL_HALT_EN only)
//  halted          out  1   fetch halted on illegal instr (tied 0 without macro)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, state=IDLE;
//    imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, halted=0.
//    Reset mid-operation discards all in-flight/buffered fetches; memory must be reset alongside.
//  - FSM: IDLE -> RUN unconditionally after one cycle; RUN -> HALT (macro only); HALT exits only via reset.
//  - Request: in RUN, imem_req_valid=1 iff (outstanding + fifo_count) < FIFO_DEPTH. imem_req_addr=pc.
//    Valid/addr held stable until accepted. On req fire: pc <= pc+4 (mod 2^32 wrap), outstanding++.
//  - Response: on imem_rsp_valid outstanding--. If drop_cnt>0: discard word, drop_cnt--.
//    Else push {data, pc-of-request} into FIFO; entry visible on instr_valid next cycle (1-cycle latency).
//    Request PC tracked in a parallel PC queue alongside outstanding requests.
//  - Decode: instr_valid = FIFO non-empty; instr/instr_pc = head. Pop on instr_valid&&instr_ready.
//    Simultaneous push and pop when full is legal (credit rule guarantees no overflow).
//  - Redirect (priority over all): FIFO flushed (incl. entry popped same cycle: pop counts, rest gone);
//    drop_cnt <= outstanding + req_fire - rsp_fire (all in-flight after this edge); rsp arriving this
//    cycle discarded; pc <= {redirect_pc[31:2],2'b00}; a request firing this cycle is dropped, not re-issued.
//    Request on next cycle uses the new pc. Redirect in IDLE/HALT: pc updated only.
//  - Counters: outstanding, drop_cnt, fifo_count each $clog2(FIFO_DEPTH)+1 bits; never exceed FIFO_DEPTH.
//  - rsp_valid with outstanding==0 is a protocol error (assertion), word ignored.
// CONFIGURATION
//  FETCH_ILLEGAL_HALT_EN defined: when instr_valid && illegal_in, state -> HALT next edge;
//  in HALT imem_req_valid=0, instr_valid=0, halted=1, in-flight responses absorbed and discarded.
//  Not defined: illegal_in ignored, halted tied 0, no HALT state.
// STRUCTURE
//  Shared package rv32_pkg: opcode constants, ALU op encodings, RESET_PC default, NOP word
//  32'h0000_0013, fetch FSM state encoding (IDLE/RUN/HALT).
//  Sub-module fetch_fifo: synchronous FIFO {pc,instr} with push/pop/flush, count, full/empty.
// TESTING
//  1. Reset, imem_req_ready=1, 1-cycle mem, instr_ready=1 -> addrs 0x0,0x4,0x8...; instr_pc matches, 1 cycle after rsp.
//  2. instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH requests issued, then req_valid=0 until pop.
//  3. Redirect to 0x100 with 2 fetches in flight -> both responses dropped; next instr_pc=0x100.
//  4. Redirect 0x203 same cycle as req fire and rsp -> next addr 0x200, stale words never reach decode.
//  5. RESET_PC=32'hFFFF_FFF8 -> addrs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0 (wrap).
//  6. Macro on: illegal_in=1 with instr_valid -> halted=1 next cycle, no further req/instr; rst_n=0 recovers.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: opcodes, ALU op encodings, reset PC, NOP word,
// fetch FSM states and the fetch buffer entry layout.
package rv32_pkg;

  localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] RV_NOP      = 32'h0000_0013;  // addi x0, x0, 0

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched {pc, instr} entries with push/pop/flush.
// Flush wins over push and pop; a pop on empty and a push on full without a
// simultaneous pop are ignored.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  // Status, head and qualified push/pop.
  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == CW'(DEPTH));
    count   = cnt_q;
    dout    = mem_q[rd_q];
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
  end

  // Next pointers/storage; flush empties the buffer outright.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + 1'b1;
      end
      if (pop_ok) rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited memory requests, in-order
// response buffering and redirect flushing.
// Optional feature macro: FETCH_ILLEGAL_HALT_EN (halt on decoder illegal flag).
module fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RV_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        illegal_in,
  output logic        halted
);
  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam int            CW      = AW + 1;
  localparam logic [CW:0]   DEPTH_X = (CW+1)'(FIFO_DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [31:0]   pcq_q [FIFO_DEPTH];
  logic [31:0]   pcq_d [FIFO_DEPTH];
  logic [AW-1:0] pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic [63:0]   fifo_dout;
  fetch_entry_t  head, push_entry;
  logic          running, req_fire, rsp_fire, redir, push, pop, halt_now;
  logic          unused_ok;

`ifdef FETCH_ILLEGAL_HALT_EN
  assign halt_now  = instr_valid && illegal_in;
  assign halted    = (state_q == FS_HALT);
  assign unused_ok = fifo_full;
`else
  assign halt_now  = 1'b0;
  assign halted    = 1'b0;
  assign unused_ok = fifo_full ^ illegal_in;
`endif

  // Handshakes, credit check and decode-side outputs.
  always_comb begin
    running        = (state_q == FS_RUN);
    imem_req_valid = running && (({1'b0, out_q} + {1'b0, fifo_count}) < DEPTH_X);
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_fire       = imem_rsp_valid && (out_q != '0);
    redir          = redirect_valid && running;
    head           = fetch_entry_t'(fifo_dout);
    instr_valid    = !fifo_empty && (state_q != FS_HALT);
    instr          = instr_valid ? head.instr : '0;
    instr_pc       = instr_valid ? head.pc    : '0;
    pop            = instr_valid && instr_ready;
    // Words still owed from before a redirect, or arriving with one, are discarded.
    push           = rsp_fire && (drop_q == '0) && !redir && running;
    push_entry     = '{pc: pcq_q[pq_rd_q], instr: imem_rsp_data};
  end

  // FSM next state: one idle cycle after reset, HALT is sticky until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_IDLE: state_d = FS_RUN;
      FS_RUN:  if (halt_now) state_d = FS_HALT;
      default: state_d = state_q;
    endcase
  end

  // PC, outstanding and drop counters; redirect overrides the PC increment.
  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q + CW'(req_fire) - CW'(rsp_fire);
    drop_d = drop_q;
    if (req_fire) pc_d = pc_q + 32'd4;
    if (rsp_fire && (drop_q != '0)) drop_d = drop_q - 1'b1;
    if (redirect_valid) begin
      pc_d = word_align(redirect_pc);
      // Everything still in flight after this edge belongs to the old path.
      if (running) drop_d = out_q + CW'(req_fire) - CW'(rsp_fire);
    end
  end

  // Request-PC queue: one slot per outstanding request, popped by every
  // response (dropped or not) so it stays aligned with memory order.
  always_comb begin
    pcq_d   = pcq_q;
    pq_wr_d = pq_wr_q;
    pq_rd_d = pq_rd_q;
    if (req_fire) begin
      pcq_d[pq_wr_q] = pc_q;
      pq_wr_d        = pq_wr_q + 1'b1;
    end
    if (rsp_fire) pq_rd_d = pq_rd_q + 1'b1;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) pcq_q[i] <= '0;
      pq_wr_q <= '0;
      pq_rd_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      pcq_q   <= pcq_d;
      pq_wr_q <= pq_wr_d;
      pq_rd_q <= pq_rd_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .din   (push_entry),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A response with nothing outstanding is a memory protocol violation.
  a_rsp_protocol: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && (out_q == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected request addresses
// and expected decode-side PCs; a negedge monitor pops and compares.
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'h1357_9BDF;  // memory word = addr ^ KEY

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        illegal_in, halted;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .illegal_in(illegal_in), .halted(halted)
  );

  // Second instance checks PC wrap from a high reset PC.
  logic        w_req_valid, w_instr_valid, w_halted;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_req_addr, w_instr, w_instr_pc;
  logic [31:0] w_rsp_data = '0;

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instr_valid(w_instr_valid), .instr_ready(1'b1), .instr(w_instr), .instr_pc(w_instr_pc),
    .illegal_in(1'b0), .halted(w_halted)
  );

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endfunction

  function automatic void fail(input string nm, input int act, input int exp);
    n_chk++;
    $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] req_q[$];
  logic [31:0] ipc_q[$];
  logic [31:0] mon_e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req_valid && imem_req_ready) begin
        if (req_q.size() == 0) fail("unexpected_req", int'(imem_req_addr), -1);
        else begin
          mon_e = req_q.pop_front();
          chk("req_addr", imem_req_addr, mon_e);
        end
      end
      if (instr_valid && instr_ready) begin
        if (ipc_q.size() == 0) fail("unexpected_instr", int'(instr_pc), -1);
        else begin
          mon_e = ipc_q.pop_front();
          chk("instr_pc", instr_pc, mon_e);
          chk("instr_word", instr, mon_e ^ KEY);
        end
      end
    end
  end

  // ---------------- memory model (in order, configurable latency) ----------------
  typedef struct { logic [31:0] data; int due; } mem_ent_t;
  mem_ent_t mem_q[$];
  mem_ent_t mem_h;
  int cyc = 0;
  int mem_lat = 1;

  always @(negedge clk)
    if (rst_n && imem_req_valid && imem_req_ready)
      mem_q.push_back('{data: imem_req_addr ^ KEY, due: cyc + mem_lat});

  always @(posedge clk) begin
    #1;
    cyc++;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      mem_h          = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_h.data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  // Wrap-instance memory (1 cycle) and capture of its first addresses/instr.
  logic        w_pend = 1'b0;
  logic [31:0] w_pend_addr = '0;
  logic [31:0] w_addrs[$];
  logic [31:0] w_first_pc = '0, w_first_ins = '0;
  bit          w_got = 1'b0;

  always @(negedge clk) begin
    w_pend      = rst_n && w_req_valid;
    w_pend_addr = w_req_addr;
    if (rst_n && w_req_valid && w_addrs.size() < 3) w_addrs.push_back(w_req_addr);
    if (rst_n && w_instr_valid && !w_got) begin
      w_got       = 1'b1;
      w_first_pc  = w_instr_pc;
      w_first_ins = w_instr;
    end
  end

  always @(posedge clk) begin
    #1;
    w_rsp_valid = w_pend;
    w_rsp_data  = w_pend_addr ^ KEY;
  end

  // ---------------- helpers ----------------
  // Hold req_ready high until n requests have been accepted.
  task automatic wait_fires(input int n);
    int got = 0;
    imem_req_ready = 1'b1;
    for (int k = 0; k < 60 && got < n; k++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) got++;
    end
    if (got < n) fail("fire_timeout", got, n);
    @(posedge clk); #1 imem_req_ready = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (ipc_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (ipc_q.size() != 0) fail("drain_timeout", ipc_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n, input bit delivered);
    for (int i = 0; i < n; i++) begin
      req_q.push_back(start + 32'(4 * i));
      if (delivered) ipc_q.push_back(start + 32'(4 * i));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  fires;
    bit  seen;
    rst_n = 1'b0; imem_req_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    instr_ready = 1'b1; illegal_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid",   32'(imem_req_valid), 32'h0);
    chk("rst_req_addr",    imem_req_addr,       32'h0);
    chk("rst_instr_valid", 32'(instr_valid),    32'h0);
    chk("rst_instr",       instr,               32'h0);
    chk("rst_instr_pc",    instr_pc,            32'h0);
    chk("rst_halted",      32'(halted),         32'h0);
    chk("rst_w_addr",      w_req_addr,          32'hFFFF_FFF8);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: sequential stream, 1-cycle memory, decode always ready.
    expect_seq(32'h0, 6, 1'b1);
    fork
      wait_fires(6);
      begin
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
          @(negedge clk);
          if (imem_rsp_valid) seen = 1'b1;
        end
        if (!seen) fail("first_rsp_timeout", 0, 1);
        @(negedge clk);
        chk("lat_instr_valid", 32'(instr_valid), 32'h1);
        chk("lat_instr_pc",    instr_pc,         32'h0);
      end
    join
    drain();

    // 2: decode stalled -> only FIFO_DEPTH requests issued.
    instr_ready = 1'b0;
`ifndef FETCH_ILLEGAL_HALT_EN
    illegal_in = 1'b1;  // must have no effect in this build
`endif
    expect_seq(32'h18, 2, 1'b1);
    imem_req_ready = 1'b1;
    fires = 0;
    repeat (10) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) fires++;
    end
    chk("credit_fires", 32'(fires), 32'd2);
    chk("credit_stall", 32'(imem_req_valid), 32'h0);
    @(posedge clk); #1 imem_req_ready = 1'b0; instr_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      @(negedge clk);
      if (imem_req_valid) seen = 1'b1;
    end
    chk("credit_return", 32'(seen), 32'h1);
    illegal_in = 1'b0;
    drain();
    chk("no_halt_default", 32'(halted), 32'h0);

    // 3: redirect to 0x100 with two fetches in flight.
    mem_lat = 4;
    expect_seq(32'h20, 2, 1'b0);
    wait_fires(2);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(posedge clk); #1 redirect_valid = 1'b0; mem_lat = 1;
    chk("redir_addr", imem_req_addr, 32'h100);
    expect_seq(32'h100, 3, 1'b1);
    wait_fires(3);
    drain();

    // 4: redirect to 0x203 in a cycle with both a request fire and a response.
    expect_seq(32'h10C, 2, 1'b0);
    expect_seq(32'h200, 3, 1'b1);
    imem_req_ready = 1'b1;
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    @(negedge clk);
    chk("coincide", {30'h0, imem_req_valid && imem_req_ready, imem_rsp_valid}, 32'h3);
    @(posedge clk); #1 redirect_valid = 1'b0;
    chk("redir_aligned", imem_req_addr, 32'h200);
    chk("redir_req_valid", 32'(imem_req_valid), 32'h1);
    wait_fires(3);
    drain();

`ifdef FETCH_ILLEGAL_HALT_EN
    // 6: illegal instruction halts fetch; reset recovers.
    instr_ready = 1'b0;
    expect_seq(32'h20C, 2, 1'b0);
    wait_fires(2);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (instr_valid) seen = 1'b1;
    end
    chk("halt_pre_valid", 32'(seen), 32'h1);
    @(posedge clk); #1 illegal_in = 1'b1;
    @(posedge clk); #1 illegal_in = 1'b0;
    @(negedge clk);
    chk("halt_flag",        32'(halted),         32'h1);
    chk("halt_req_valid",   32'(imem_req_valid), 32'h0);
    chk("halt_instr_valid", 32'(instr_valid),    32'h0);
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    fires = 0;
    repeat (5) begin
      @(negedge clk);
      if (imem_req_valid || instr_valid) fires++;
    end
    chk("halt_quiet", 32'(fires), 32'h0);
    @(posedge clk); #1 imem_req_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk); mem_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    chk("halt_rst_flag", 32'(halted), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    expect_seq(32'h0, 2, 1'b1);
    wait_fires(2);
    drain();
`endif

    // 5: wrap from RESET_PC 0xFFFF_FFF8 (second instance).
    if (w_addrs.size() == 3) begin
      chk("wrap_addr0", w_addrs[0], 32'hFFFF_FFF8);
      chk("wrap_addr1", w_addrs[1], 32'hFFFF_FFFC);
      chk("wrap_addr2", w_addrs[2], 32'h0000_0000);
    end else fail("wrap_addr_count", w_addrs.size(), 3);
    chk("wrap_first_pc",  w_first_pc,  32'hFFFF_FFF8);
    chk("wrap_first_ins", w_first_ins, 32'hFFFF_FFF8 ^ KEY);
    chk("wrap_halted",    32'(w_halted), 32'h0);

    chk("req_q_left", 32'(req_q.size()), 32'h0);
    chk("ipc_q_left", 32'(ipc_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d checks, expected completion", n_chk);
    $fatal(1);
  end

endmodule
